// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp codes, funct constants, multiplier FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ALUOP_LDST = 2'b00,
    ALUOP_BR   = 2'b01,
    ALUOP_R    = 2'b10,
    ALUOP_I    = 2'b11
  } aluop_e;

  // {funct7, funct3}
  localparam logic [9:0] FN_ADD  = 10'b0000000_000;
  localparam logic [9:0] FN_SUB  = 10'b0100000_000;
  localparam logic [9:0] FN_AND  = 10'b0000000_111;
  localparam logic [9:0] FN_OR   = 10'b0000000_110;
  localparam logic [9:0] FN_XOR  = 10'b0000000_100;
  localparam logic [9:0] FN_SLL  = 10'b0000000_001;
  localparam logic [9:0] FN_MUL  = 10'b0000001_000;
  localparam logic [9:0] FN_SRAI = 10'b0100000_101;

  // I-type ops are selected on funct3 alone
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SRAI = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; MUL_EARLY_TERM_EN stops once no set bits remain.
// Latency: MUL_CYCLES busy cycles (fewer with MUL_EARLY_TERM_EN); prod_o is valid while last_o is high.
// Backpressure: none; caller holds operands via its stall and may abort at any cycle.
module mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            abort_i,
  input  logic            go_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            last_o,
  output logic [XLEN-1:0] prod_o
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, addend;
  logic [CW-1:0]   cnt_q;
  logic            done;

  // The final partial product is folded in combinationally so the product is ready on the last cycle.
  assign addend = mplier_q[0] ? mcand_q : '0;
  assign prod_o = acc_q + addend;

`ifdef MUL_EARLY_TERM_EN
  assign done = (cnt_q == LAST_CNT) || (mplier_q[XLEN-1:1] == '0);
`else
  assign done = (cnt_q == LAST_CNT);
`endif

  assign busy_o = (state_q == BUSY);
  assign last_o = busy_o && done;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start on go, leave on abort or completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_i && !abort_i) state_d = BUSY;
      BUSY:    if (abort_i || done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture in IDLE, one shift-add step per BUSY cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (go_i) begin
        acc_q    <= '0;
        mcand_q  <= a_i;
        mplier_q <= b_i;
        cnt_q    <= '0;
      end
    end else begin
      acc_q    <= prod_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage fused with the EX/MEM register: ALU, branch resolve, iterative MUL (MUL_EARLY_TERM_EN shortens MUL).
// Latency: 1 cycle for non-MUL; MUL result appears the cycle after stall_o falls.
// Backpressure: stall_o (combinational) freezes upstream while a MUL runs; start_i low flushes a bubble.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            Branch_i,
  input  logic            MemRead_i,
  input  logic            MemtoReg_i,
  input  logic            MemWrite_i,
  input  logic            ALUSrc_i,
  input  logic            RegWrite_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      RDaddr_i,
  output logic [XLEN-1:0] ALUresult_o,
  output logic [XLEN-1:0] RS2data_o,
  output logic [4:0]      RDaddr_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            MemtoReg_o,
  output logic            RegWrite_o,
  output logic            BranchTaken_o,
  output logic [XLEN-1:0] BranchTarget_o,
  output logic            stall_o
);

  logic [XLEN-1:0] op_b, alu_res, prod;
  logic            is_mul, mul_go, mul_busy, mul_last;
  logic [2:0]      funct3;
  mem_ctrl_t       ctrl_q;

  assign op_b   = ALUSrc_i ? imm_i : RS2data_i;
  assign funct3 = funct_i[2:0];

  // ALU decode; undefined codes yield 0 while control still propagates
  always_comb begin
    alu_res = '0;
    is_mul  = 1'b0;
    case (ALUOp_i)
      ALUOP_LDST: alu_res = RS1data_i + op_b;
      ALUOP_BR:   alu_res = RS1data_i - op_b;
      ALUOP_R: begin
        case (funct_i)
          FN_ADD:  alu_res = RS1data_i + op_b;
          FN_SUB:  alu_res = RS1data_i - op_b;
          FN_AND:  alu_res = RS1data_i & op_b;
          FN_OR:   alu_res = RS1data_i | op_b;
          FN_XOR:  alu_res = RS1data_i ^ op_b;
          FN_SLL:  alu_res = RS1data_i << op_b[4:0];
          FN_MUL:  is_mul  = 1'b1;
          default: alu_res = '0;
        endcase
      end
      ALUOP_I: begin
        if (funct3 == F3_ADDI)      alu_res = RS1data_i + op_b;
        else if (funct3 == F3_SRAI) alu_res = $unsigned($signed(RS1data_i) >>> imm_i[4:0]);
      end
      default: alu_res = '0;
    endcase
  end

  // A held MUL instruction must not re-launch while the multiplier is busy with it.
  assign mul_go  = start_i && is_mul && !mul_busy;
  assign stall_o = start_i && (mul_busy ? !mul_last : is_mul);

  mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .abort_i (!start_i),
    .go_i    (mul_go),
    .a_i     (RS1data_i),
    .b_i     (op_b),
    .busy_o  (mul_busy),
    .last_o  (mul_last),
    .prod_o  (prod)
  );

  // EX/MEM register: bubble on reset, flush or stall; otherwise ALU or final MUL result
  always_ff @(posedge clk_i) begin
    if (rst_i || !start_i || stall_o) begin
      ALUresult_o    <= '0;
      RS2data_o      <= '0;
      RDaddr_o       <= '0;
      ctrl_q         <= '0;
      BranchTaken_o  <= 1'b0;
      BranchTarget_o <= '0;
    end else begin
      ALUresult_o    <= mul_busy ? prod : alu_res;
      RS2data_o      <= RS2data_i;
      RDaddr_o       <= RDaddr_i;
      ctrl_q         <= '{mem_read: MemRead_i, mem_write: MemWrite_i,
                          mem_to_reg: MemtoReg_i, reg_write: RegWrite_i};
      BranchTaken_o  <= Branch_i && (RS1data_i == RS2data_i);
      BranchTarget_o <= pc_i + (imm_i << 1);
    end
  end

  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;
  assign RegWrite_o = ctrl_q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; stall-length expectations follow MUL_EARLY_TERM_EN.
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next.
// Backpressure: MUL waits are bounded by a 40-cycle budget.
module tb_ex_stage;
  import ex_pkg::*;

`ifdef MUL_EARLY_TERM_EN
  localparam int E_FULL = 17;
  localparam int E_6X5  = 3;
  localparam int E_6X0  = 1;
`else
  localparam int E_FULL = 32;
  localparam int E_6X5  = 32;
  localparam int E_6X0  = 32;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] pc_i, RS1data_i, RS2data_i, imm_i;
  logic        Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i;
  logic [1:0]  ALUOp_i;
  logic [9:0]  funct_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] ALUresult_o, RS2data_o, BranchTarget_o;
  logic [4:0]  RDaddr_o;
  logic        MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o, BranchTaken_o, stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .Branch_i(Branch_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .RS1data_i(RS1data_i),
    .RS2data_i(RS2data_i), .imm_i(imm_i), .RDaddr_i(RDaddr_i),
    .ALUresult_o(ALUresult_o), .RS2data_o(RS2data_o), .RDaddr_o(RDaddr_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o), .BranchTaken_o(BranchTaken_o),
    .BranchTarget_o(BranchTarget_o), .stall_o(stall_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [9:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic src,
                        input logic [4:0] rd);
    ALUOp_i = op;  funct_i = fn;  RS1data_i = a;  RS2data_i = b;  imm_i = im;
    ALUSrc_i = src;  RDaddr_i = rd;  RegWrite_i = 1'b1;
    Branch_i = 1'b0;  MemRead_i = 1'b0;  MemWrite_i = 1'b0;  MemtoReg_i = 1'b0;  pc_i = '0;
  endtask

  task automatic set_nop();
    set_op(2'b00, 10'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    RegWrite_i = 1'b0;
  endtask

  // Applies a MUL, counts stall cycles within a budget, then checks the written-back result.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int exp_stall, input logic [31:0] exp_prod);
    int n = 0;
    int bad = 0;
    set_op(ALUOP_R, FN_MUL, a, b, 32'd0, 1'b0, rd);
    #1;
    while (stall_o === 1'b1 && n < 40) begin
      if (n > 0 && RegWrite_o !== 1'b0) bad++;
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_quiet_regwrite"}, 32'(bad), 32'd0);
    tick();
    chk({tag, "_prod"}, ALUresult_o, exp_prod);
    chk({tag, "_rd"}, 32'(RDaddr_o), 32'(rd));
    chk({tag, "_regwrite"}, 32'(RegWrite_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1;  start_i = 1'b0;  set_nop();
    tick();  tick();
    chk("rst_alu", ALUresult_o, 32'd0);
    chk("rst_rd", 32'(RDaddr_o), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst_target", BranchTarget_o, 32'd0);
    rst_i = 1'b0;  start_i = 1'b1;  #1;
    chk("rst_stall", 32'(stall_o), 32'd0);

    // R-type / I-type pipeline, one result per cycle
    set_op(ALUOP_R, FN_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 5'd1);  tick();
    chk("add", ALUresult_o, 32'd12);
    chk("add_rd", 32'(RDaddr_o), 32'd1);
    set_op(ALUOP_R, FN_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 5'd2);  tick();
    chk("sub", ALUresult_o, 32'hFFFF_FFFE);
    set_op(ALUOP_R, FN_SLL, 32'd1, 32'd31, 32'd0, 1'b0, 5'd3);  tick();
    chk("sll", ALUresult_o, 32'h8000_0000);
    set_op(ALUOP_I, FN_SRAI, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd4);  tick();
    chk("srai", ALUresult_o, 32'hF800_0000);
    set_op(ALUOP_I, 10'b0, 32'd23, 32'd0, 32'd100, 1'b1, 5'd5);  tick();
    chk("addi", ALUresult_o, 32'd123);
    set_op(ALUOP_R, FN_AND, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd1);  tick();
    chk("and", ALUresult_o, 32'hF000);
    set_op(ALUOP_R, FN_OR, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd1);  tick();
    chk("or", ALUresult_o, 32'hFFF0);
    set_op(ALUOP_R, FN_XOR, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd1);  tick();
    chk("xor", ALUresult_o, 32'h0FF0);
    set_op(ALUOP_R, 10'h3FF, 32'd9, 32'd9, 32'd0, 1'b0, 5'd6);  tick();
    chk("undef_res", ALUresult_o, 32'd0);
    chk("undef_regwrite", 32'(RegWrite_o), 32'd1);
    chk("undef_rd", 32'(RDaddr_o), 32'd6);

    // Store address and data
    set_op(ALUOP_LDST, 10'b0, 32'h1000, 32'hDEAD, 32'd8, 1'b1, 5'd0);
    RegWrite_i = 1'b0;  MemWrite_i = 1'b1;  tick();
    chk("st_addr", ALUresult_o, 32'h1008);
    chk("st_data", RS2data_o, 32'hDEAD);
    chk("st_memwrite", 32'(MemWrite_o), 32'd1);
    chk("st_regwrite", 32'(RegWrite_o), 32'd0);

    // Branch resolve
    set_op(ALUOP_BR, 10'b0, 32'd42, 32'd42, 32'd8, 1'b0, 5'd0);
    RegWrite_i = 1'b0;  Branch_i = 1'b1;  pc_i = 32'h100;  tick();
    chk("br_taken", 32'(BranchTaken_o), 32'd1);
    chk("br_target", BranchTarget_o, 32'h110);
    RS2data_i = 32'd43;  tick();
    chk("br_not_taken", 32'(BranchTaken_o), 32'd0);
    chk("br_target2", BranchTarget_o, 32'h110);

    // MUL, including back-to-back
    run_mul("mul_full", 32'h0000_FFFF, 32'h0001_0001, 5'd9, E_FULL, 32'hFFFF_FFFF);
    run_mul("mul_6x5", 32'd6, 32'd5, 5'd10, E_6X5, 32'd30);
    run_mul("mul_6x0", 32'd6, 32'd0, 5'd11, E_6X0, 32'd0);

    // Flush at counter 5
    set_op(ALUOP_R, FN_MUL, 32'd3, 32'h8000_0000, 32'd0, 1'b0, 5'd7);
    repeat (6) tick();
    chk("flush_pre_stall", 32'(stall_o), 32'd1);
    start_i = 1'b0;  #1;
    chk("flush_stall_drop", 32'(stall_o), 32'd0);
    tick();
    chk("flush_bubble_rw", 32'(RegWrite_o), 32'd0);
    chk("flush_bubble_res", ALUresult_o, 32'd0);
    start_i = 1'b1;  set_nop();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_wb", 32'(RegWrite_o), 32'd0);
    end
    set_op(ALUOP_R, FN_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd3);  tick();
    chk("flush_then_add", ALUresult_o, 32'd30);

    // Reset at counter 10
    set_op(ALUOP_R, FN_MUL, 32'h1234, 32'h8000_0000, 32'd0, 1'b0, 5'd5);
    repeat (11) tick();
    chk("rstmul_pre_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;  set_nop();  tick();
    rst_i = 1'b0;  #1;
    chk("rstmul_alu", ALUresult_o, 32'd0);
    chk("rstmul_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rstmul_rd", 32'(RDaddr_o), 32'd0);
    chk("rstmul_stall", 32'(stall_o), 32'd0);
    set_op(ALUOP_R, FN_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 5'd8);  tick();
    chk("rstmul_add", ALUresult_o, 32'd4);
    chk("rstmul_add_rd", 32'(RDaddr_o), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
